// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the control sequencer.
// Holds the FSM state enum, opcode and ALU code constants, and the
// bundle of datapath controls produced by the decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_STORE = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  // Any code without a dedicated meaning behaves as a NOP; this one is
  // used when an opcode has non-zero bits above the low nibble.
  localparam logic [3:0] OP_NOP   = 4'b0101;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  localparam int CTRL_W = 13;

  typedef struct packed {
    logic       ir_load;
    logic       pc_en;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       mem_req;
    logic       done;
    logic [3:0] alu_op;
  } ctrl_t;

  // Quiescent control word: everything off, ALU passes operand A.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c        = ctrl_t'({CTRL_W{1'b0}});
    c.alu_op = ALU_PASS;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational map from {state, opcode, equal, mem_ack}
// to the datapath control word. Outputs are Moore in state/opcode except
// Branch (follows equal in EXEC) and the STORE completion pc_en, which
// marks the MEM cycle in which the handshake finishes.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  input  logic       equal,
  input  logic       mem_ack,
  output ctrl_t      ctrl
);

  // Decode the control word for the current state and latched opcode
  always_comb begin
    ctrl = ctrl_idle();
    case (state)
      S_FETCH: begin
        ctrl.ir_load = 1'b1;
      end
      S_EXEC: begin
        case (op)
          OP_ADD: begin
            ctrl.alu_op = ALU_ADD;
          end
          OP_ADDI: begin
            ctrl.alu_src = 1'b1;
            ctrl.alu_op  = ALU_ADD;
          end
          OP_BEQ: begin
            ctrl.alu_op = ALU_SUB;
            ctrl.branch = equal;
            ctrl.pc_en  = 1'b1;
          end
          OP_STORE, OP_LOAD, OP_HALT: begin
            ctrl.alu_op = ALU_PASS;
          end
          default: begin
            ctrl.pc_en = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_src = 1'b1;
        if (op == OP_STORE) begin
          ctrl.mem_write = 1'b1;
          ctrl.pc_en     = mem_ack;
        end else begin
          ctrl.mem_write = 1'b0;
          ctrl.pc_en     = 1'b0;
        end
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.pc_en      = 1'b1;
        ctrl.mem_to_reg = (op == OP_LOAD);
      end
      S_HALT: begin
        ctrl.done = 1'b1;
      end
      default: begin
        ctrl = ctrl_idle();
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control unit. Latches the opcode in
// FETCH, walks each instruction through DECODE/EXEC/MEM/WB, waits on the
// data-memory handshake and parks in HALT until reset.
// Build option: define CTRL_PERF_CNT_EN to build the cycle/instruction
// performance counters; otherwise both counter outputs are tied to zero.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int ALUOPW = 4,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OPW-1:0]    instr,
  input  logic              equal,
  input  logic              mem_ack,
  output logic              ir_load,
  output logic              pc_en,
  output logic              Branch,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              MemtoReg,
  output logic              ALUSrc,
  output logic              mem_req,
  output logic              done,
  output logic [ALUOPW-1:0] ALUOp,
  output logic [CNTW-1:0]   cycle_cnt,
  output logic [CNTW-1:0]   instr_cnt
);

  state_t         state_r;
  state_t         next_state_s;
  logic [OPW-1:0] op_q_r;
  logic [3:0]     op4_s;
  logic           upper_zero_s;
  ctrl_t          ctrl_s;

  // Opcodes live in the low nibble; anything set above it is a NOP.
  assign upper_zero_s = ((op_q_r >> 3'd4) == {OPW{1'b0}});
  assign op4_s        = upper_zero_s ? op_q_r[3:0] : OP_NOP;

  // State register and opcode latch (opcode captured in FETCH)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      op_q_r  <= {OPW{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (state_r == S_FETCH) begin
        op_q_r <= instr;
      end else begin
        op_q_r <= op_q_r;
      end
    end
  end

  // Next-state sequencing per state and latched opcode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: next_state_s = S_EXEC;
      S_EXEC: begin
        case (op4_s)
          OP_STORE, OP_LOAD: next_state_s = S_MEM;
          OP_ADD, OP_ADDI:   next_state_s = S_WB;
          OP_HALT:           next_state_s = S_HALT;
          default:           next_state_s = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!mem_ack) begin
          next_state_s = S_MEM;
        end else if (op4_s == OP_LOAD) begin
          next_state_s = S_WB;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_WB:    next_state_s = S_FETCH;
      S_HALT:  next_state_s = S_HALT;
      default: next_state_s = S_IDLE;
    endcase
  end

  ctrl_decode u_decode (
    .state   (state_r),
    .op      (op4_s),
    .equal   (equal),
    .mem_ack (mem_ack),
    .ctrl    (ctrl_s)
  );

  assign ir_load  = ctrl_s.ir_load;
  assign pc_en    = ctrl_s.pc_en;
  assign Branch   = ctrl_s.branch;
  assign RegWrite = ctrl_s.reg_write;
  assign MemWrite = ctrl_s.mem_write;
  assign MemtoReg = ctrl_s.mem_to_reg;
  assign ALUSrc   = ctrl_s.alu_src;
  assign mem_req  = ctrl_s.mem_req;
  assign done     = ctrl_s.done;
  assign ALUOp    = ALUOPW'(ctrl_s.alu_op);

`ifdef CTRL_PERF_CNT_EN
  logic [CNTW-1:0] cycle_cnt_r;
  logic [CNTW-1:0] instr_cnt_r;
  logic            cycle_inc_s;
  logic            instr_inc_s;

  // Busy cycles are everything outside IDLE and HALT; retirements are
  // pc_en cycles plus the step into HALT.
  assign cycle_inc_s = (state_r != S_IDLE) && (state_r != S_HALT);
  assign instr_inc_s = ctrl_s.pc_en || ((state_r == S_EXEC) && (op4_s == OP_HALT));

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_r <= {CNTW{1'b0}};
      instr_cnt_r <= {CNTW{1'b0}};
    end else begin
      if (cycle_inc_s && (cycle_cnt_r != {CNTW{1'b1}})) begin
        cycle_cnt_r <= cycle_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (instr_inc_s && (instr_cnt_r != {CNTW{1'b1}})) begin
        instr_cnt_r <= instr_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        instr_cnt_r <= instr_cnt_r;
      end
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign instr_cnt = instr_cnt_r;
`else
  assign cycle_cnt = {CNTW{1'b0}};
  assign instr_cnt = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: self-checking bench for control_sequencer.
// An instruction-level reference (phase script per opcode plus a control
// table per phase) predicts every output cycle by cycle; directed vectors
// check latency, random programs exercise ignored inputs and HALT.
module tb_control_sequencer;

  localparam int          CNTW = 6;
  localparam int unsigned CMAX = (32'd1 << CNTW) - 32'd1;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, start, equal, mem_ack;
  logic [3:0]      instr;
  logic            ir_load, pc_en, Branch, RegWrite, MemWrite, MemtoReg;
  logic            ALUSrc, mem_req, done;
  logic [3:0]      ALUOp;
  logic [CNTW-1:0] cycle_cnt, instr_cnt;

  control_sequencer #(.OPW(4), .ALUOPW(4), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .equal(equal),
    .mem_ack(mem_ack), .ir_load(ir_load), .pc_en(pc_en), .Branch(Branch),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .mem_req(mem_req), .done(done), .ALUOp(ALUOp),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef enum {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_HALT} phase_t;

  typedef struct packed {
    logic       ir_load, pc_en, branch, reg_write, mem_write, mem_to_reg;
    logic       alu_src, mem_req, done;
    logic [3:0] alu_op;
  } outs_t;

  typedef struct {
    logic [3:0] op;
    int         nwait;
    logic       eq;
    int         lat;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned m_cyc = 0;
  int unsigned m_ins = 0;
  int          since_fetch = 0;

  function automatic int unsigned sat_inc(int unsigned v);
    return (v >= CMAX) ? CMAX : v + 32'd1;
  endfunction

  // Control table per instruction phase.
  function automatic outs_t expect_outs(phase_t ph, logic [3:0] op, logic eq, logic ack);
    outs_t o;
    o = '0;
    o.alu_op = 4'b1111;
    case (ph)
      P_FETCH: o.ir_load = 1'b1;
      P_EXEC: begin
        case (op)
          4'd1: o.alu_op = 4'd0;
          4'd3: begin o.alu_src = 1'b1; o.alu_op = 4'd0; end
          4'd4: begin o.alu_op = 4'd1; o.branch = eq; o.pc_en = 1'b1; end
          4'd0, 4'd2, 4'd15: o.alu_op = 4'b1111;
          default: o.pc_en = 1'b1;
        endcase
      end
      P_MEM: begin
        o.mem_req = 1'b1;
        o.alu_op  = 4'd0;
        o.alu_src = 1'b1;
        if (op == 4'd0) begin
          o.mem_write = 1'b1;
          o.pc_en     = ack;
        end
      end
      P_WB: begin
        o.reg_write  = 1'b1;
        o.pc_en      = 1'b1;
        o.mem_to_reg = (op == 4'd2);
      end
      P_HALT: o.done = 1'b1;
      default: o.done = 1'b0;
    endcase
    return o;
  endfunction

  task automatic check_cycle(phase_t ph, logic [3:0] op, logic eq, logic ack, string tag);
    outs_t       e, a;
    int unsigned ec, ei;
    e  = expect_outs(ph, op, eq, ack);
    a  = {ir_load, pc_en, Branch, RegWrite, MemWrite, MemtoReg, ALUSrc, mem_req, done, ALUOp};
    ec = PERF ? m_cyc : 32'd0;
    ei = PERF ? m_ins : 32'd0;
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s ctl (phase %s op %0d): got %b want %b", tag, ph.name(), op, a, e);
    end
    n_cmp++;
    if (cycle_cnt !== CNTW'(ec) || instr_cnt !== CNTW'(ei)) begin
      n_bad++;
      $display("FAIL %s cnt: got cyc=%0d ins=%0d want cyc=%0d ins=%0d",
               tag, cycle_cnt, instr_cnt, ec, ei);
    end
    if (ph != P_IDLE && ph != P_HALT) m_cyc = sat_inc(m_cyc);
    if (e.pc_en || (ph == P_EXEC && op == 4'd15)) m_ins = sat_inc(m_ins);
    if (ir_load === 1'b1) since_fetch = 1;
    else since_fetch++;
  endtask

  // Called at a negedge: drive one cycle of inputs, check, move to next negedge.
  task automatic one_cycle(phase_t ph, logic [3:0] op, logic eq, logic ack, logic st, string tag);
    start   = st;
    instr   = (ph == P_FETCH) ? op  : 4'($urandom);
    equal   = (ph == P_EXEC)  ? eq  : 1'($urandom);
    mem_ack = (ph == P_MEM)   ? ack : 1'($urandom);
    #1;
    check_cycle(ph, op, equal, mem_ack, tag);
    @(negedge clk);
  endtask

  // Phase script of one instruction starting in its FETCH cycle.
  task automatic run_instr(logic [3:0] op, int nwait, logic eq, string tag);
    one_cycle(P_FETCH,  op, eq, 1'b0, 1'($urandom), tag);
    one_cycle(P_DECODE, op, eq, 1'b0, 1'($urandom), tag);
    one_cycle(P_EXEC,   op, eq, 1'b0, 1'($urandom), tag);
    if (op == 4'd0 || op == 4'd2) begin
      for (int k = 0; k <= nwait; k++)
        one_cycle(P_MEM, op, eq, (k == nwait), 1'($urandom), tag);
    end
    if (op == 4'd1 || op == 4'd2 || op == 4'd3)
      one_cycle(P_WB, op, eq, 1'b0, 1'($urandom), tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'($urandom);
    mem_ack = 1'($urandom);
    @(negedge clk);
    reset = 1'b0;
    m_cyc = 0;
    m_ins = 0;
    since_fetch = 0;
  endtask

  task automatic idle_cycles(int n, string tag);
    for (int i = 0; i < n; i++) one_cycle(P_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic halt_cycles(int n);
    for (int i = 0; i < n; i++) one_cycle(P_HALT, 4'd15, 1'b0, 1'b0, 1'($urandom), "halt_hold");
  endtask

  task automatic random_program(int n);
    logic [3:0] op;
    one_cycle(P_IDLE, 4'd0, 1'b0, 1'b0, 1'b1, "rnd_start");
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op, $urandom_range(0, 4), 1'($urandom), "rnd");
    end
    run_instr(4'd15, 0, 1'b0, "rnd_halt");
    halt_cycles(20);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{4'd1,  0, 1'b0, 4}, '{4'd3,  0, 1'b1, 4}, '{4'd4,  0, 1'b1, 3},
      '{4'd4,  0, 1'b0, 3}, '{4'd5,  0, 1'b1, 3}, '{4'd10, 0, 1'b0, 3},
      '{4'd2,  3, 1'b0, 8}, '{4'd2,  0, 1'b1, 5}, '{4'd0,  0, 1'b0, 4},
      '{4'd0,  2, 1'b1, 6}, '{4'd1,  0, 1'b1, 4}
    };
    reset = 1'b1; start = 1'b0; instr = 4'd0; equal = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    idle_cycles(10, "reset_idle");

    // Directed vectors: each instruction's latency is measured at the next FETCH.
    one_cycle(P_IDLE, 4'd0, 1'b0, 1'b0, 1'b1, "start");
    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].nwait, vecs[i].eq, $sformatf("vec%0d", i));
      #1;
      n_cmp++;
      if (ir_load !== 1'b1 || since_fetch != vecs[i].lat) begin
        n_bad++;
        $display("FAIL vec%0d latency: got ir_load=%b after %0d cycles want 1 after %0d",
                 i, ir_load, since_fetch, vecs[i].lat);
      end
    end

    // STORE with reset during the second memory wait cycle.
    one_cycle(P_FETCH,  4'd0, 1'b0, 1'b0, 1'b0, "rst_mem");
    one_cycle(P_DECODE, 4'd0, 1'b0, 1'b0, 1'b0, "rst_mem");
    one_cycle(P_EXEC,   4'd0, 1'b0, 1'b0, 1'b0, "rst_mem");
    one_cycle(P_MEM,    4'd0, 1'b0, 1'b0, 1'b0, "rst_mem");
    reset = 1'b1; mem_ack = 1'b0; start = 1'b0;
    #1;
    check_cycle(P_MEM, 4'd0, equal, 1'b0, "rst_mem_w2");
    @(negedge clk);
    reset = 1'b0;
    m_cyc = 0;
    m_ins = 0;
    idle_cycles(10, "rst_mem_after");

    // Random programs, each ending in HALT held against start pulses.
    for (int r = 0; r < 3; r++) begin
      random_program(30);
      do_reset();
      idle_cycles(2, "rnd_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
